// File: rtl/bgr_pkg.sv
// Shared types and width helpers for the background-removal pixel engine.
package bgr_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_BG  = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sum_w(input int cw, input int n);
        return cw + idx_w(n);
    endfunction

    function automatic int dist_w(input int cw);
        return 2 * cw + 2;
    endfunction

endpackage

// File: rtl/bgr_dist_sq.sv
// Squared Euclidean distance of one RGB pixel from the expected background colour.
module bgr_dist_sq
    import bgr_pkg::*;
#(
    parameter  int CW     = 8,
    localparam int DIST_W = dist_w(CW)
) (
    input  logic [CW-1:0]     r_i,
    input  logic [CW-1:0]     g_i,
    input  logic [CW-1:0]     b_i,
    input  logic [CW-1:0]     re_i,
    input  logic [CW-1:0]     ge_i,
    input  logic [CW-1:0]     be_i,
    output logic [DIST_W-1:0] dist_o
);

    // Absolute difference keeps the operands unsigned and avoids wrap-around.
    function automatic logic [2*CW-1:0] sq_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return (2 * CW)'(d) * (2 * CW)'(d);
    endfunction

    assign dist_o = DIST_W'(sq_diff(r_i, re_i))
                  + DIST_W'(sq_diff(g_i, ge_i))
                  + DIST_W'(sq_diff(b_i, be_i));

endmodule

// File: rtl/bgr_pixel_engine.sv
// Per-slice pixel engine: SUM accumulates channel totals, BG swaps near-background pixels.
// Optional BGR_FG_MASK_EN adds fg_mask reporting which pixels were kept in the last BG job.
module bgr_pixel_engine
    import bgr_pkg::*;
#(
    parameter  int NUM_PIXELS = 4,
    parameter  int CW         = 8,
    localparam int SUM_W      = sum_w(CW, NUM_PIXELS),
    localparam int DIST_W     = dist_w(CW),
    localparam int PW         = CW * NUM_PIXELS
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic              Ack,
    input  logic [PW-1:0]     red_in,
    input  logic [PW-1:0]     green_in,
    input  logic [PW-1:0]     blue_in,
    input  logic [CW-1:0]     red_exp,
    input  logic [CW-1:0]     green_exp,
    input  logic [CW-1:0]     blue_exp,
    input  logic [DIST_W-1:0] threshold,
    input  logic [CW-1:0]     bg_r,
    input  logic [CW-1:0]     bg_g,
    input  logic [CW-1:0]     bg_b,
    output logic [PW-1:0]     red_out,
    output logic [PW-1:0]     green_out,
    output logic [PW-1:0]     blue_out,
    output logic [SUM_W-1:0]  red_sum,
    output logic [SUM_W-1:0]  green_sum,
    output logic [SUM_W-1:0]  blue_sum,
    output logic              Busy,
    output logic              Done,
    output logic [3:0]        state_o
`ifdef BGR_FG_MASK_EN
    ,
    output logic [NUM_PIXELS-1:0] fg_mask
`endif
);

    localparam int            IDX_W = idx_w(NUM_PIXELS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PIXELS - 1);

    state_e state_q, state_d;
    logic   done_entry;

    logic                  mode_q;
    logic [PW-1:0]         pix_r_q, pix_g_q, pix_b_q;
    logic [CW-1:0]         exp_r_q, exp_g_q, exp_b_q;
    logic [CW-1:0]         bgc_r_q, bgc_g_q, bgc_b_q;
    logic [DIST_W-1:0]     thr_q;

    logic [IDX_W-1:0]      idx_q, sel_idx_q, dist_idx_q;
    logic                  fetch_done_q, sel_vld_q, dist_vld_q;
    logic [CW-1:0]         sel_r_q, sel_g_q, sel_b_q;
    logic [DIST_W-1:0]     dist_q, dist_d;
    logic                  kept;

    logic [SUM_W-1:0]      acc_r_q, acc_g_q, acc_b_q, acc_r_d, acc_g_d, acc_b_d;
    logic [PW-1:0]         res_r_q, res_g_q, res_b_q, res_r_d, res_g_d, res_b_d;
    logic [NUM_PIXELS-1:0] keep_q, keep_d;

    bgr_dist_sq #(.CW(CW)) u_dist (
        .r_i    (sel_r_q),
        .g_i    (sel_g_q),
        .b_i    (sel_b_q),
        .re_i   (exp_r_q),
        .ge_i   (exp_g_q),
        .be_i   (exp_b_q),
        .dist_o (dist_d)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // The pixel being processed is the registered fetch (sel_*), one cycle behind idx.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (Start) state_d = ST_RUN;
            ST_RUN:   if (sel_vld_q && sel_idx_q == LAST)
                          state_d = (mode_q == MODE_BG) ? ST_DRAIN : ST_DONE;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (Ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        Busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        Done       = (state_q == ST_DONE);
        state_o    = state_q;
        done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    assign kept = dist_q > thr_q;

    always_comb begin
        acc_r_d = acc_r_q;
        acc_g_d = acc_g_q;
        acc_b_d = acc_b_q;
        res_r_d = res_r_q;
        res_g_d = res_g_q;
        res_b_d = res_b_q;
        keep_d  = keep_q;
        if (state_q == ST_RUN && sel_vld_q && mode_q == MODE_SUM) begin
            acc_r_d = acc_r_q + SUM_W'(sel_r_q);
            acc_g_d = acc_g_q + SUM_W'(sel_g_q);
            acc_b_d = acc_b_q + SUM_W'(sel_b_q);
        end
        if (dist_vld_q) begin
            res_r_d[dist_idx_q*CW +: CW] = kept ? pix_r_q[dist_idx_q*CW +: CW] : bgc_r_q;
            res_g_d[dist_idx_q*CW +: CW] = kept ? pix_g_q[dist_idx_q*CW +: CW] : bgc_g_q;
            res_b_d[dist_idx_q*CW +: CW] = kept ? pix_b_q[dist_idx_q*CW +: CW] : bgc_b_q;
            keep_d[dist_idx_q]           = kept;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mode_q       <= 1'b0;
            pix_r_q      <= '0;
            pix_g_q      <= '0;
            pix_b_q      <= '0;
            exp_r_q      <= '0;
            exp_g_q      <= '0;
            exp_b_q      <= '0;
            bgc_r_q      <= '0;
            bgc_g_q      <= '0;
            bgc_b_q      <= '0;
            thr_q        <= '0;
            idx_q        <= '0;
            sel_idx_q    <= '0;
            dist_idx_q   <= '0;
            fetch_done_q <= 1'b0;
            sel_vld_q    <= 1'b0;
            dist_vld_q   <= 1'b0;
            sel_r_q      <= '0;
            sel_g_q      <= '0;
            sel_b_q      <= '0;
            dist_q       <= '0;
            acc_r_q      <= '0;
            acc_g_q      <= '0;
            acc_b_q      <= '0;
            res_r_q      <= '0;
            res_g_q      <= '0;
            res_b_q      <= '0;
            keep_q       <= '0;
        end else if (state_q == ST_IDLE && Start) begin
            mode_q       <= Mode;
            pix_r_q      <= red_in;
            pix_g_q      <= green_in;
            pix_b_q      <= blue_in;
            exp_r_q      <= red_exp;
            exp_g_q      <= green_exp;
            exp_b_q      <= blue_exp;
            bgc_r_q      <= bg_r;
            bgc_g_q      <= bg_g;
            bgc_b_q      <= bg_b;
            thr_q        <= threshold;
            idx_q        <= '0;
            fetch_done_q <= 1'b0;
            sel_vld_q    <= 1'b0;
            dist_vld_q   <= 1'b0;
            acc_r_q      <= '0;
            acc_g_q      <= '0;
            acc_b_q      <= '0;
        end else begin
            sel_vld_q  <= (state_q == ST_RUN) && !fetch_done_q;
            dist_vld_q <= (state_q == ST_RUN) && sel_vld_q && (mode_q == MODE_BG);
            if (state_q == ST_RUN && !fetch_done_q) begin
                sel_r_q   <= pix_r_q[idx_q*CW +: CW];
                sel_g_q   <= pix_g_q[idx_q*CW +: CW];
                sel_b_q   <= pix_b_q[idx_q*CW +: CW];
                sel_idx_q <= idx_q;
                if (idx_q == LAST) fetch_done_q <= 1'b1;
                else               idx_q        <= idx_q + IDX_W'(1);
            end
            if (state_q == ST_RUN && sel_vld_q) begin
                dist_q     <= dist_d;
                dist_idx_q <= sel_idx_q;
            end
            acc_r_q <= acc_r_d;
            acc_g_q <= acc_g_d;
            acc_b_q <= acc_b_d;
            res_r_q <= res_r_d;
            res_g_q <= res_g_d;
            res_b_q <= res_b_d;
            keep_q  <= keep_d;
        end
    end

    // Results are published from the next-state values so the final pixel lands on DONE entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            red_sum   <= '0;
            green_sum <= '0;
            blue_sum  <= '0;
`ifdef BGR_FG_MASK_EN
            fg_mask   <= '0;
`endif
        end else if (done_entry) begin
            if (mode_q == MODE_BG) begin
                red_out   <= res_r_d;
                green_out <= res_g_d;
                blue_out  <= res_b_d;
`ifdef BGR_FG_MASK_EN
                fg_mask   <= keep_d;
`endif
            end else begin
                red_sum   <= acc_r_d;
                green_sum <= acc_g_d;
                blue_sum  <= acc_b_d;
            end
        end
    end

endmodule
